// File: rtl/save_pkg.sv
// Shared types for the save-register write sequencer.
package save_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first req bit at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner
);
  logic found;

  // Offsets are walked in priority order; only a definite 1 counts as a request.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (req[i] === 1'b1) && (((int'(ptr) + k) % NREQ) == i)) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/save_controller.sv
// Round-robin write sequencer for a bank of save registers (IDLE->SAVE->DONE).
// Optional write protection via the SAVE_PROTECT_EN macro (adds wp_mask/err).
module save_controller
  import save_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREQ   = 2,
  parameter int NSLOTS = 4,
  localparam int ADDR_W = $clog2(NSLOTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  req_num,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
`ifdef SAVE_PROTECT_EN
  input  logic [NSLOTS-1:0]      wp_mask,
  output logic [NREQ-1:0]        err,
`endif
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NSLOTS-1:0]      ok_save,
  output logic [WIDTH-1:0]       num_out,
  output logic                   busy
);
  localparam int PTR_W = $clog2(NREQ);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [NSLOTS-1:0]   ok_save_q, ok_save_d;
  logic [WIDTH-1:0]    num_out_q, num_out_d;
  logic                busy_q, busy_d;
  logic [NREQ-1:0]     win;
  logic [WIDTH-1:0]    win_num;
  logic [ADDR_W-1:0]   win_addr;
  logic [PTR_W-1:0]    gnt_idx;
  logic                blocked;
`ifdef SAVE_PROTECT_EN
  logic [NREQ-1:0]     err_q, err_d;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .winner(win)
  );

  always_comb begin
    win_num  = '0;
    win_addr = '0;
    gnt_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_num  = req_num[i*WIDTH +: WIDTH];
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
      if (gnt_q[i]) gnt_idx = PTR_W'(i);
    end
  end

  // ok_save_q already holds the decoded slot, so the mask is applied to it directly.
`ifdef SAVE_PROTECT_EN
  assign blocked = |(ok_save_q & wp_mask);
  assign ok_save = ok_save_q & ~wp_mask;
  assign err     = err_q;
`else
  assign blocked = 1'b0;
  assign ok_save = ok_save_q;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    ok_save_d = '0;
    num_out_d = num_out_q;
`ifdef SAVE_PROTECT_EN
    err_d     = '0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d     = '0;
        num_out_d = '0;
        if (|win) begin
          state_d             = SAVE;
          gnt_d               = win;
          num_out_d           = win_num;
          ok_save_d[win_addr] = 1'b1;
        end
      end
      SAVE: begin
        state_d = DONE;
        done_d  = gnt_q;
`ifdef SAVE_PROTECT_EN
        err_d   = blocked ? gnt_q : '0;
`endif
      end
      DONE: begin
        state_d   = IDLE;
        rr_ptr_d  = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        gnt_d     = '0;
        num_out_d = '0;
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        num_out_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      ok_save_q <= '0;
      num_out_q <= '0;
      busy_q    <= 1'b0;
`ifdef SAVE_PROTECT_EN
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      ok_save_q <= ok_save_d;
      num_out_q <= num_out_d;
      busy_q    <= busy_d;
`ifdef SAVE_PROTECT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign num_out = num_out_q;
  assign busy    = busy_q;
endmodule

// File: doc/save_controller.md
Name: save_controller

Overview:
- Sequences writes into a bank of NSLOTS WIDTH-bit save registers. Each register is built from a hold/load selector plus flop.
- Arbitrates between NREQ requesters using round-robin priority.
- Drives a one-hot per-slot load strobe (ok_save) and a shared data bus (num_out) to the bank.
- Returns a one-cycle completion pulse to the winning requester.

Parameters:
- WIDTH, 8, data width of each save register and of num_out
- NREQ, 2, number of requesters (2..8)
- NSLOTS, 4, number of save registers (power of two, 2..16)
- ADDR_W, $clog2(NSLOTS), slot address width (derived; not overridden)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester save request (level)
- req_num  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- req_addr  in  NREQ*ADDR_W  requester i target slot in bits [i*ADDR_W +: ADDR_W]
- gnt  out  NREQ  one-hot, current owner of the bank
- done  out  NREQ  one-cycle completion pulse to the owner
- ok_save  out  NSLOTS  one-hot load strobe, one bit per save register
- num_out  out  WIDTH  data presented to the save registers
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; rr pointer = 0.
  - gnt, done, ok_save, num_out, busy all 0.
- States: IDLE -> SAVE -> DONE -> IDLE. There are no other transitions, and the unused encoding returns to IDLE.
- IDLE:
  - If any req bit is high, select the winner. Winner = first requester with req high, searching from the rr pointer upward with wrap (index NREQ-1 wraps to 0).
  - Register gnt (one-hot winner) and capture the winner's num and addr into internal registers. Next state is SAVE.
  - With no req, stay in IDLE with all outputs 0.
- SAVE (exactly 1 cycle):
  - ok_save = one-hot decode of the captured addr.
  - num_out = captured num.
  - gnt is held. Next state is DONE.
- DONE (exactly 1 cycle):
  - done[winner] = 1; ok_save = 0; num_out holds its value.
  - rr pointer = (winner + 1) mod NREQ. Next state is IDLE.
  - gnt clears on entry to IDLE.
- Latency: req sampled high in IDLE at edge N -> ok_save high during cycle N+1 -> done high during cycle N+2.
  - Maximum throughput is one save every 3 cycles.
- Handshake:
  - A requester keeps req, req_num and req_addr stable until it sees done.
  - The controller captures data in IDLE, so later changes do not affect the write in progress.
  - If req is still high in the IDLE cycle after done, that is a new request. It competes normally; the rr pointer has already moved past this requester.
- Simultaneous requests: exactly one winner per arbitration. Losers wait with no loss of their request.
- Dropping req while not granted simply withdraws the request. Dropping req after capture does not abort the save.
- At most one ok_save bit is high in any cycle, and only in SAVE.
- Reset mid-operation: an in-flight ok_save or done is cancelled immediately (asynchronously). No partial write strobe occurs after rst asserts.
- Any unknown or X value on req in IDLE is treated as a request only when the bit is 1.

Optional Feature:
- Macro SAVE_PROTECT_EN.
- When defined:
  - Add input wp_mask (NSLOTS) and output err (NREQ).
  - In SAVE, if wp_mask[captured addr] = 1, ok_save stays 0.
  - In DONE, err[winner] pulses together with done[winner].
  - wp_mask is sampled in the SAVE cycle.
  - err resets to 0.
- When undefined: no wp_mask or err ports, and all saves are performed.

Decomposition:
- Package save_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, SAVE, DONE}
  - localparam default WIDTH = 8
- Sub-module rr_arbiter (NREQ):
  - Inputs: req, ptr. Output: one-hot winner.
  - Purely combinational.
  - The pointer register stays in save_controller.

Test Plan:
- Reset, no requests: after rst release, idle 10 cycles -> ok_save, gnt, done, busy all 0 throughout; assert rst mid-SAVE -> ok_save drops to 0 the same cycle.
- Single save: req[0]=1, num=8'hA5, addr=2 at edge N -> ok_save=4'b0100 and num_out=8'hA5 in cycle N+1; done[0]=1 in cycle N+2 only.
- Contention: req=2'b11 from reset with num0=8'h11/addr 0 and num1=8'h22/addr 3, held until each is done -> requester 0 is served first (ok_save=0001, 8'h11), then requester 1 (ok_save=1000, 8'h22). Exactly 6 cycles in total.
- Fairness: req=2'b11 held continuously for 12 cycles -> grants alternate 0,1,0,1; each done arrives 3 cycles apart.
- Data capture: change req_num from 8'h33 to 8'h44 during SAVE -> num_out stays 8'h33 and the written value is 8'h33.
- SAVE_PROTECT_EN: wp_mask=4'b0010, save to addr 1 -> ok_save stays 0000 and done[0] and err[0] pulse together; a save to addr 0 proceeds normally with err=0.
